// File: rtl/regfile_fwd_sb.sv
// Integer register file with NUM_RD forwarding read ports and a pending-load scoreboard.
// Optional stall counter is enabled by defining REGFILE_FWD_SB_PERF_CNT_EN.

module regfile_fwd_sb_rdport #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic                       rst,
    input  logic                       re,
    input  logic [AW-1:0]              addr,
    input  logic                       ex_we,
    input  logic                       ex_is_load,
    input  logic [AW-1:0]              ex_waddr,
    input  logic [XLEN-1:0]            ex_alu,
    input  logic                       mem_we,
    input  logic                       mem_is_load,
    input  logic [AW-1:0]              mem_waddr,
    input  logic [XLEN-1:0]            mem_wdata,
    input  logic                       wb_we,
    input  logic [AW-1:0]              wb_waddr,
    input  logic [XLEN-1:0]            wb_wdata,
    input  logic [NREGS-1:0][XLEN-1:0] regs,
    input  logic [NREGS-1:0]           busy,
    output logic [XLEN-1:0]            data,
    output logic                       stall
);
    logic in_range;
    assign in_range = int'(addr) < NREGS;

    // Youngest producer wins; a load still in flight at that stage stalls instead.
    always_comb begin
        data  = '0;
        stall = 1'b0;
        if (!rst || !re || addr == '0 || !in_range) begin
            data = '0;
        end else if (ex_we && ex_waddr == addr) begin
            if (ex_is_load) stall = 1'b1;
            else            data  = ex_alu;
        end else if (mem_we && mem_waddr == addr) begin
            if (mem_is_load) stall = 1'b1;
            else             data  = mem_wdata;
        end else if (wb_we && wb_waddr == addr) begin
            data = wb_wdata;
        end else if (busy[addr]) begin
            stall = 1'b1;
        end else begin
            data = regs[addr];
        end
    end
endmodule

module regfile_fwd_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_we_i,
    input  logic [AW-1:0]          wb_waddr_i,
    input  logic [XLEN-1:0]        wb_wdata_i,
    input  logic                   mem_we_i,
    input  logic                   mem_is_load_i,
    input  logic [AW-1:0]          mem_waddr_i,
    input  logic [XLEN-1:0]        mem_wdata_i,
    input  logic                   ex_we_i,
    input  logic                   ex_is_load_i,
    input  logic [AW-1:0]          ex_waddr_i,
    input  logic [XLEN-1:0]        ex_alu_i,
    input  logic                   ex_issue_i,
    input  logic                   flush_i,
    input  logic [NUM_RD-1:0]      re_i,
    input  logic [NUM_RD*AW-1:0]   raddr_i,
    output logic [NUM_RD*XLEN-1:0] rdata_o,
    output logic                   stallreq_o
`ifdef REGFILE_FWD_SB_PERF_CNT_EN
    ,
    output logic [31:0]            stall_cnt_o
`endif
);
    logic [NREGS-1:0][XLEN-1:0]  regs;
    logic [NREGS-1:0]            busy;
    logic [NUM_RD-1:0][XLEN-1:0] port_data;
    logic [NUM_RD-1:0]           port_stall;
    logic                        sb_set;

    assign sb_set = ex_issue_i && ex_we_i && ex_is_load_i && ex_waddr_i != '0 && !flush_i;

    // Set is applied after clear so a younger load to the same rd stays pending.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regs <= '0;
            busy <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wb_we_i && wb_waddr_i == AW'(i)) begin
                    regs[i] <= wb_wdata_i;
                    busy[i] <= 1'b0;
                end
                if (sb_set && ex_waddr_i == AW'(i))
                    busy[i] <= 1'b1;
            end
            regs[0] <= '0;
            busy[0] <= 1'b0;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_RD; k++) begin : g_rd
            regfile_fwd_sb_rdport #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_rd (
                .rst        (rst),
                .re         (re_i[k]),
                .addr       (raddr_i[k*AW +: AW]),
                .ex_we      (ex_we_i),
                .ex_is_load (ex_is_load_i),
                .ex_waddr   (ex_waddr_i),
                .ex_alu     (ex_alu_i),
                .mem_we     (mem_we_i),
                .mem_is_load(mem_is_load_i),
                .mem_waddr  (mem_waddr_i),
                .mem_wdata  (mem_wdata_i),
                .wb_we      (wb_we_i),
                .wb_waddr   (wb_waddr_i),
                .wb_wdata   (wb_wdata_i),
                .regs       (regs),
                .busy       (busy),
                .data       (port_data[k]),
                .stall      (port_stall[k])
            );
            assign rdata_o[k*XLEN +: XLEN] = port_data[k];
        end
    endgenerate

    assign stallreq_o = |port_stall;

`ifdef REGFILE_FWD_SB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst)
            stall_cnt_o <= '0;
        else if (stallreq_o && stall_cnt_o != 32'hFFFF_FFFF)
            stall_cnt_o <= stall_cnt_o + 32'd1;
    end
`endif
endmodule

// File: tb/tb_regfile_fwd_sb.sv
// Directed plus randomized check of regfile_fwd_sb against a rule-level reference model.

module tb_regfile_fwd_sb;
    localparam int XLEN = 32, NREGS = 32, AW = 5, NUM_RD = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic                   wb_we, mem_we, mem_is_load, ex_we, ex_is_load, ex_issue, flush;
    logic [AW-1:0]          wb_waddr, mem_waddr, ex_waddr;
    logic [XLEN-1:0]        wb_wdata, mem_wdata, ex_alu;
    logic [NUM_RD-1:0]      re;
    logic [NUM_RD*AW-1:0]   raddr;
    logic [NUM_RD*XLEN-1:0] rdata;
    logic                   stallreq;
`ifdef REGFILE_FWD_SB_PERF_CNT_EN
    logic [31:0]            stall_cnt;
`endif

    regfile_fwd_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NUM_RD(NUM_RD)) dut (
        .clk(clk), .rst(rst),
        .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
        .mem_we_i(mem_we), .mem_is_load_i(mem_is_load), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
        .ex_we_i(ex_we), .ex_is_load_i(ex_is_load), .ex_waddr_i(ex_waddr), .ex_alu_i(ex_alu),
        .ex_issue_i(ex_issue), .flush_i(flush),
        .re_i(re), .raddr_i(raddr), .rdata_o(rdata), .stallreq_o(stallreq)
`ifdef REGFILE_FWD_SB_PERF_CNT_EN
        , .stall_cnt_o(stall_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference state: architectural values, pending-load flags, stall count.
    logic [XLEN-1:0] m_regs [NREGS];
    logic            m_busy [NREGS];
    logic [31:0]     m_cnt;

    function automatic void m_read(input int k, output logic [XLEN-1:0] d, output logic s);
        int a;
        a = int'(raddr[k*AW +: AW]);
        d = '0;
        s = 1'b0;
        if (rst && re[k] && a != 0 && a < NREGS) begin
            if (ex_we && int'(ex_waddr) == a) begin
                if (ex_is_load) s = 1'b1; else d = ex_alu;
            end else if (mem_we && int'(mem_waddr) == a) begin
                if (mem_is_load) s = 1'b1; else d = mem_wdata;
            end else if (wb_we && int'(wb_waddr) == a) begin
                d = wb_wdata;
            end else if (m_busy[a]) begin
                s = 1'b1;
            end else begin
                d = m_regs[a];
            end
        end
    endfunction

    function automatic logic m_stall();
        logic [XLEN-1:0] d;
        logic s, any;
        any = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            m_read(k, d, s);
            any |= s;
        end
        return any;
    endfunction

    task automatic m_update();
        logic st;
        st = m_stall();
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
            m_cnt = '0;
        end else begin
            if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (wb_we && wb_waddr != 0) begin
                m_regs[wb_waddr] = wb_wdata;
                m_busy[wb_waddr] = 1'b0;
            end
            if (ex_issue && ex_we && ex_is_load && ex_waddr != 0 && !flush)
                m_busy[ex_waddr] = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [XLEN-1:0] d;
        logic s;
        for (int k = 0; k < NUM_RD; k++) begin
            m_read(k, d, s);
            chk($sformatf("%s.rdata%0d", tag, k), rdata[k*XLEN +: XLEN], d);
        end
        chk({tag, ".stall"}, 32'(stallreq), 32'(m_stall()));
`ifdef REGFILE_FWD_SB_PERF_CNT_EN
        chk({tag, ".cnt"}, stall_cnt, m_cnt);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    task automatic idle();
        wb_we = 0; wb_waddr = 0; wb_wdata = 0;
        mem_we = 0; mem_is_load = 0; mem_waddr = 0; mem_wdata = 0;
        ex_we = 0; ex_is_load = 0; ex_waddr = 0; ex_alu = 0;
        ex_issue = 0; flush = 0;
    endtask

    task automatic rd(input int k, input int a);
        re[k] = 1'b1;
        raddr[k*AW +: AW] = AW'(a);
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
        m_cnt = '0;
        rst = 0; re = '0; raddr = '0;
        idle();

        // Reset: outputs gated even with a matching EX load.
        @(negedge clk);
        rd(0, 5); rd(1, 7);
        ex_we = 1; ex_is_load = 1; ex_waddr = 7;
        #1;
        chk("rst.rdata", rdata, '0);
        chk("rst.stall", 32'(stallreq), 0);
        tick(); tick();
        rst = 1; idle(); #1;
        check_model("post_rst");

        // Write then read, with same-cycle bypass.
        wb_we = 1; wb_waddr = 5; wb_wdata = 32'h1234; rd(0, 5); #1;
        chk("wr.bypass", rdata[31:0], 32'h1234);
        chk("wr.bypass_stall", 32'(stallreq), 0);
        tick(); idle(); #1;
        chk("wr.read", rdata[31:0], 32'h1234);
        chk("wr.read_stall", 32'(stallreq), 0);

        // Forward priority EX > MEM > WB.
        rd(0, 3);
        ex_we = 1; ex_waddr = 3; ex_alu = 32'hA;
        mem_we = 1; mem_waddr = 3; mem_wdata = 32'hB;
        wb_we = 1; wb_waddr = 3; wb_wdata = 32'hC; #1;
        chk("fwd.ex", rdata[31:0], 32'hA);
        ex_we = 0; #1;
        chk("fwd.mem", rdata[31:0], 32'hB);
        idle();

        // Load-use on port 1 moving through EX, MEM, WB.
        rd(1, 7); ex_we = 1; ex_is_load = 1; ex_waddr = 7; #1;
        chk("lu.ex_stall", 32'(stallreq), 1);
        chk("lu.ex_data", rdata[63:32], 0);
        idle(); mem_we = 1; mem_is_load = 1; mem_waddr = 7; #1;
        chk("lu.mem_stall", 32'(stallreq), 1);
        idle(); wb_we = 1; wb_waddr = 7; wb_wdata = 32'h55; #1;
        chk("lu.wb_data", rdata[63:32], 32'h55);
        chk("lu.wb_stall", 32'(stallreq), 0);
        tick(); idle(); re = '0;

        // Scoreboard holds a multi-cycle load.
        ex_we = 1; ex_is_load = 1; ex_waddr = 9; ex_issue = 1;
        tick(); idle(); rd(0, 9);
        for (int c = 0; c < 3; c++) begin
            #1; chk($sformatf("sb.wait%0d", c), 32'(stallreq), 1);
            tick();
        end
        wb_we = 1; wb_waddr = 9; wb_wdata = 32'h99; #1;
        chk("sb.ret_data", rdata[31:0], 32'h99);
        chk("sb.ret_stall", 32'(stallreq), 0);
        tick(); idle(); #1;
        chk("sb.cleared", 32'(stallreq), 0);
        chk("sb.value", rdata[31:0], 32'h99);

        // Set beats clear; flush suppresses a set.
        re = '0; wb_we = 1; wb_waddr = 4; wb_wdata = 32'h44;
        ex_we = 1; ex_is_load = 1; ex_waddr = 4; ex_issue = 1;
        tick(); idle(); rd(0, 4); #1;
        chk("col.busy", 32'(stallreq), 1);
        wb_we = 1; wb_waddr = 4; wb_wdata = 32'h40; tick(); idle();
        ex_we = 1; ex_is_load = 1; ex_waddr = 4; ex_issue = 1; flush = 1; re = '0;
        tick(); idle(); rd(0, 4); #1;
        chk("flush.nobusy", 32'(stallreq), 0);
        chk("flush.data", rdata[31:0], 32'h40);

        // x0 is hardwired.
        wb_we = 1; wb_waddr = 0; wb_wdata = 32'hFFFF; tick(); idle(); rd(0, 0); rd(1, 0); #1;
        chk("x0.read", rdata, '0);

        // Mid-operation reset forgets pending loads and values.
        ex_we = 1; ex_is_load = 1; ex_waddr = 12; ex_issue = 1; tick(); idle();
        rst = 0; tick(); rst = 1; rd(0, 12); rd(1, 5); #1;
        chk("rst2.stall", 32'(stallreq), 0);
        chk("rst2.rdata", rdata, '0);
`ifdef REGFILE_FWD_SB_PERF_CNT_EN
        chk("rst2.cnt", stall_cnt, 0);
`endif
        check_model("rst2");

        // Randomized traffic with dense address collisions.
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 99) != 0);
            wb_we       = $urandom_range(0, 1);
            wb_waddr    = AW'($urandom_range(0, 7));
            wb_wdata    = $urandom;
            mem_we      = ($urandom_range(0, 2) == 0);
            mem_is_load = $urandom_range(0, 1);
            mem_waddr   = AW'($urandom_range(0, 7));
            mem_wdata   = $urandom;
            ex_we       = ($urandom_range(0, 2) == 0);
            ex_is_load  = $urandom_range(0, 1);
            ex_waddr    = AW'($urandom_range(0, 7));
            ex_alu      = $urandom;
            ex_issue    = $urandom_range(0, 1);
            flush       = ($urandom_range(0, 4) == 0);
            re          = NUM_RD'($urandom);
            for (int k = 0; k < NUM_RD; k++)
                raddr[k*AW +: AW] = AW'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 31)
                                                                   : $urandom_range(0, 7));
            #1;
            check_model($sformatf("rnd%0d", c));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
